// File: rtl/edge_detect_multi.sv
`default_nettype none
// ============================================================================
// Module   : edge_detect_multi
// Purpose  : Per-channel synchroniser, debouncer and mode-selected edge
//            detector with active-low pulse, sticky flag and shared IRQ.
// Revision : 1.0
// ============================================================================
module edge_detect_multi #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = $clog2(DEBOUNCE + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CHANNELS-1:0]   sig_in,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   flag_clr,
    output logic [CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]   pulse_n,
    output logic [CHANNELS-1:0]   edge_flag,
    output logic                  irq_n
);

    localparam logic [1:0]       c_MODE_RISE = 2'b00;
    localparam logic [1:0]       c_MODE_FALL = 2'b01;
    localparam logic [1:0]       c_MODE_BOTH = 2'b10;
    localparam logic [CNT_W-1:0] c_CNT_LAST  = CNT_W'(DEBOUNCE - 1);

    logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
    logic [CNT_W-1:0]       cnt_q  [CHANNELS];
    logic [CNT_W-1:0]       cnt_d  [CHANNELS];
    logic [CHANNELS-1:0]    level_q, level_d;
    logic [CHANNELS-1:0]    pulse_n_q, pulse_n_d;
    logic [CHANNELS-1:0]    flag_q, flag_d;
    logic                   irq_n_q;
    logic [CHANNELS-1:0]    w_evt;
    logic [CHANNELS-1:0]    w_qual;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i]   = cnt_q[i];
            level_d[i] = level_q[i];
            w_evt[i]   = 1'b0;
            if (sync_q[i][SYNC_STAGES-1] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == c_CNT_LAST) begin
                level_d[i] = ~level_q[i];
                cnt_d[i]   = '0;
                w_evt[i]   = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            // Qualification looks at the level being entered, not the old one.
            w_qual[i] = w_evt[i] &
                        (((mode[2*i +: 2] == c_MODE_RISE) &  level_d[i]) |
                         ((mode[2*i +: 2] == c_MODE_FALL) & ~level_d[i]) |
                          (mode[2*i +: 2] == c_MODE_BOTH));
            pulse_n_d[i] = ~w_qual[i];
            flag_d[i]    = w_qual[i] | (flag_q[i] & ~flag_clr[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            level_q   <= '0;
            pulse_n_q <= '1;
            flag_q    <= '0;
            irq_n_q   <= 1'b1;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], sig_in[i]};
                cnt_q[i]  <= cnt_d[i];
            end
            level_q   <= level_d;
            pulse_n_q <= pulse_n_d;
            flag_q    <= flag_d;
            irq_n_q   <= ~|flag_d;
        end
    end

    assign level     = level_q;
    assign pulse_n   = pulse_n_q;
    assign edge_flag = flag_q;
    assign irq_n     = irq_n_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_detect_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_detect_multi
// Purpose  : Directed self-checking bench for edge_detect_multi (defaults).
// Revision : 1.0
// ============================================================================
module tb_edge_detect_multi;

    logic       clk;
    logic       rst_n;
    logic [3:0] sig_in;
    logic [7:0] mode;
    logic [3:0] flag_clr;
    logic [3:0] level;
    logic [3:0] pulse_n;
    logic [3:0] edge_flag;
    logic       irq_n;

    int n_total = 0;
    int n_bad   = 0;

    edge_detect_multi #(
        .CHANNELS    (4),
        .SYNC_STAGES (2),
        .DEBOUNCE    (4)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .mode      (mode),
        .flag_clr  (flag_clr),
        .level     (level),
        .pulse_n   (pulse_n),
        .edge_flag (edge_flag),
        .irq_n     (irq_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_ch2(input int first_exp, input int n_exp, input logic flag_exp,
                           input string pfx);
        int t_first;
        int t_second;
        int n_pulse;
        t_first  = -1;
        t_second = -1;
        n_pulse  = 0;
        sig_in[2] = 1'b1;
        for (int t = 1; t <= 26; t++) begin
            if (t == 11) sig_in[2] = 1'b0;
            tick(1);
            if (pulse_n[2] == 1'b0) begin
                n_pulse++;
                if (t_first < 0) t_first = t;
                else t_second = t;
            end
            if (t == 6)  check({pfx, "_lvl_up"},   {31'd0, level[2]}, 32'd1);
            if (t == 16) check({pfx, "_lvl_down"}, {31'd0, level[2]}, 32'd0);
        end
        check({pfx, "_npulse"}, n_pulse, n_exp);
        if (n_exp == 2) begin
            check({pfx, "_first"}, t_first, first_exp);
            check({pfx, "_gap"},   t_second - t_first, 32'd10);
        end
        check({pfx, "_flag"}, {31'd0, edge_flag[2]}, {31'd0, flag_exp});
    endtask

    initial begin
        logic [3:0] p_and;
        logic [3:0] l_or;
        logic [3:0] f_or;

        // 1: reset with inputs high, then release
        rst_n    = 1'b0;
        sig_in   = 4'hF;
        mode     = 8'h00;
        flag_clr = 4'h0;
        tick(3);
        check("rst_level", level, 4'h0);
        check("rst_pulse", pulse_n, 4'hF);
        check("rst_flag",  edge_flag, 4'h0);
        check("rst_irq",   irq_n, 1'b1);
        rst_n = 1'b1;
        tick(5);
        check("t1_lvl_e5",   level, 4'h0);
        check("t1_pulse_e5", pulse_n, 4'hF);
        tick(1);
        check("t1_lvl_e6",   level, 4'hF);
        check("t1_pulse_e6", pulse_n, 4'h0);
        check("t1_flag_e6",  edge_flag, 4'hF);
        check("t1_irq_e6",   irq_n, 1'b0);
        tick(1);
        check("t1_pulse_e7", pulse_n, 4'hF);
        flag_clr = 4'hF;
        tick(1);
        flag_clr = 4'h0;
        check("t1_clr_flag", edge_flag, 4'h0);
        check("t1_clr_irq",  irq_n, 1'b1);

        // 2: rising edge on ch0 from a clean zero state
        sig_in = 4'h0;
        rst_n  = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(8);
        sig_in[0] = 1'b1;
        tick(5);
        check("t2_pulse_e5", pulse_n, 4'hF);
        check("t2_lvl_e5",   level, 4'h0);
        tick(1);
        check("t2_pulse_e6", pulse_n, 4'hE);
        check("t2_lvl_e6",   level, 4'h1);
        check("t2_flag_e6",  edge_flag, 4'h1);
        check("t2_irq_e6",   irq_n, 1'b0);
        tick(1);
        check("t2_pulse_e7", pulse_n, 4'hF);
        sig_in[0] = 1'b0;
        p_and = 4'hF;
        for (int t = 0; t < 8; t++) begin
            tick(1);
            p_and &= pulse_n;
        end
        check("t2_fall_nopulse", p_and, 4'hF);
        check("t2_fall_lvl",     level, 4'h0);
        check("t2_flag_kept",    edge_flag, 4'h1);
        flag_clr = 4'h1;
        tick(1);
        flag_clr = 4'h0;
        check("t2_clr_irq", irq_n, 1'b1);

        // 3: three-cycle glitch on ch1 must be rejected
        sig_in[1] = 1'b1;
        p_and = 4'hF;
        l_or  = 4'h0;
        f_or  = 4'h0;
        for (int t = 0; t < 13; t++) begin
            if (t == 3) sig_in[1] = 1'b0;
            tick(1);
            p_and &= pulse_n;
            l_or  |= level;
            f_or  |= edge_flag;
        end
        check("t3_lvl",   l_or[1],  1'b0);
        check("t3_pulse", p_and[1], 1'b1);
        check("t3_flag",  f_or[1],  1'b0);

        // 4: both-edge mode, then disabled mode, on ch2
        mode[5:4] = 2'b10;
        run_ch2(6, 2, 1'b1, "t4_both");
        flag_clr = 4'h4;
        tick(1);
        flag_clr = 4'h0;
        mode[5:4] = 2'b11;
        run_ch2(0, 0, 1'b0, "t4_dis");
        check("t4_dis_irq", irq_n, 1'b1);
        mode[5:4] = 2'b00;

        // 5: set and clear colliding on ch3
        sig_in[3] = 1'b1;
        tick(5);
        flag_clr[3] = 1'b1;
        tick(1);
        check("t5_coll_flag",  edge_flag, 4'h8);
        check("t5_coll_pulse", pulse_n, 4'h7);
        check("t5_coll_irq",   irq_n, 1'b0);
        tick(1);
        flag_clr[3] = 1'b0;
        check("t5_clr_flag", edge_flag, 4'h0);
        check("t5_clr_irq",  irq_n, 1'b1);
        sig_in[3] = 1'b0;
        tick(8);
        check("t5_settle_lvl", level, 4'h0);

        // 6: reset mid-debounce restarts the full latency
        sig_in[0] = 1'b1;
        tick(4);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("t6_rst_lvl",   level, 4'h0);
        check("t6_rst_pulse", pulse_n, 4'hF);
        tick(5);
        check("t6_pulse_e5", pulse_n, 4'hF);
        check("t6_lvl_e5",   level, 4'h0);
        tick(1);
        check("t6_pulse_e6", pulse_n, 4'hE);
        check("t6_lvl_e6",   level, 4'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
